soc_top: RTL and testbench

SOC_TOP -- requirements
Module: soc_top

---
 rtl/soc_top_pkg.sv | 78 +++++++
 rtl/soc_top_core.sv | 212 +++++++++++++++++++++
 rtl/soc_top_mem.sv | 58 +++++
 rtl/soc_top_regfile.sv | 32 +++
 rtl/soc_top.sv | 41 ++++
 tb/tb_soc_top.sv | 307 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/soc_top_pkg.sv
// Shared constants, FSM encoding and load-lane helper for the soc_top RV32I slice.
package soc_top_pkg;

    localparam int          DATA_WIDTH  = 32;
    localparam logic        RstEnable   = 1'b0;
    localparam logic        RstDisable  = 1'b1;

    localparam logic [6:0]  OPC_LUI     = 7'b0110111;
    localparam logic [6:0]  OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0]  OPC_JAL     = 7'b1101111;
    localparam logic [6:0]  OPC_JALR    = 7'b1100111;
    localparam logic [6:0]  OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0]  OPC_LOAD    = 7'b0000011;
    localparam logic [6:0]  OPC_STORE   = 7'b0100011;
    localparam logic [6:0]  OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0]  OPC_OP      = 7'b0110011;
    localparam logic [6:0]  OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0]  OPC_SYSTEM  = 7'b1110011;

    localparam logic [2:0]  F3_ADD  = 3'b000;
    localparam logic [2:0]  F3_SLL  = 3'b001;
    localparam logic [2:0]  F3_SLT  = 3'b010;
    localparam logic [2:0]  F3_SLTU = 3'b011;
    localparam logic [2:0]  F3_XOR  = 3'b100;
    localparam logic [2:0]  F3_SR   = 3'b101;
    localparam logic [2:0]  F3_OR   = 3'b110;
    localparam logic [2:0]  F3_AND  = 3'b111;

    localparam logic [2:0]  F3_BEQ  = 3'b000;
    localparam logic [2:0]  F3_BNE  = 3'b001;
    localparam logic [2:0]  F3_BLT  = 3'b100;
    localparam logic [2:0]  F3_BGE  = 3'b101;
    localparam logic [2:0]  F3_BLTU = 3'b110;
    localparam logic [2:0]  F3_BGEU = 3'b111;

    localparam logic [2:0]  F3_LB   = 3'b000;
    localparam logic [2:0]  F3_LH   = 3'b001;
    localparam logic [2:0]  F3_LW   = 3'b010;
    localparam logic [2:0]  F3_LBU  = 3'b100;
    localparam logic [2:0]  F3_LHU  = 3'b101;
    localparam logic [2:0]  F3_SB   = 3'b000;
    localparam logic [2:0]  F3_SH   = 3'b001;
    localparam logic [2:0]  F3_SW   = 3'b010;

    localparam logic [6:0]  F7_BASE = 7'b0000000;
    localparam logic [6:0]  F7_ALT  = 7'b0100000;

    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_LOAD   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // Pick the addressed byte/halfword out of a memory word and extend per funct3.
    function automatic logic [31:0] load_extract(input logic [2:0] f3,
                                                 input logic [31:0] word,
                                                 input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_LB:   r = {{24{b[7]}}, b};
            F3_LH:   r = {{16{h[15]}}, h};
            F3_LW:   r = word;
            F3_LBU:  r = {24'd0, b};
            F3_LHU:  r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/soc_top_core.sv
// Non-pipelined RV32I core: FETCH -> DECODE -> EXEC -> (LOAD) -> FETCH.
// Define SOC_EBREAK_HALT_EN to make EBREAK freeze the core until reset.
module riscv_core
    import soc_top_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic [31:0] rs1_val_r;
    logic [31:0] rs2_val_r;

    logic [31:0] rf_rdata1_s, rf_rdata2_s;
    logic        rf_we_s;
    logic [31:0] rf_wdata_s;

    logic [6:0]  opcode_s;
    logic [4:0]  rd_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
    logic [31:0] pc_plus4_s, ls_addr_s, jalr_sum_s;
    logic [31:0] op_b_s, alu_s, next_pc_s, exec_wdata_s;
    logic [4:0]  shamt_s;
    logic        take_s, exec_we_s, is_load_s, halt_s;

    assign opcode_s   = instr_r[6:0];
    assign rd_s       = instr_r[11:7];
    assign funct3_s   = instr_r[14:12];
    assign funct7_s   = instr_r[31:25];
    assign imm_i_s    = {{20{instr_r[31]}}, instr_r[31:20]};
    assign imm_s_s    = {{20{instr_r[31]}}, instr_r[31:25], instr_r[11:7]};
    assign imm_b_s    = {{19{instr_r[31]}}, instr_r[31], instr_r[7], instr_r[30:25], instr_r[11:8], 1'b0};
    assign imm_u_s    = {instr_r[31:12], 12'd0};
    assign imm_j_s    = {{11{instr_r[31]}}, instr_r[31], instr_r[19:12], instr_r[20], instr_r[30:21], 1'b0};
    assign pc_plus4_s = pc_r + 32'd4;
    assign ls_addr_s  = rs1_val_r + ((opcode_s == OPC_STORE) ? imm_s_s : imm_i_s);
    assign jalr_sum_s = rs1_val_r + imm_i_s;
    assign is_load_s  = (opcode_s == OPC_LOAD);

`ifdef SOC_EBREAK_HALT_EN
    assign halt_s = (instr_r == INSN_EBREAK);
`else
    assign halt_s = 1'b0;
`endif

    regfile regfile_inst (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr1 (mem_rdata[19:15]),
        .raddr2 (mem_rdata[24:20]),
        .rdata1 (rf_rdata1_s),
        .rdata2 (rf_rdata2_s),
        .we     (rf_we_s),
        .waddr  (rd_s),
        .wdata  (rf_wdata_s)
    );

    // ALU shared by OP and OP-IMM; SUB only exists for register-register ops.
    always_comb begin
        op_b_s  = (opcode_s == OPC_OP) ? rs2_val_r : imm_i_s;
        shamt_s = op_b_s[4:0];
        case (funct3_s)
            F3_ADD:  alu_s = ((opcode_s == OPC_OP) && (funct7_s == F7_ALT)) ? rs1_val_r - op_b_s
                                                                            : rs1_val_r + op_b_s;
            F3_SLL:  alu_s = rs1_val_r << shamt_s;
            F3_SLT:  alu_s = {31'd0, $signed(rs1_val_r) < $signed(op_b_s)};
            F3_SLTU: alu_s = {31'd0, rs1_val_r < op_b_s};
            F3_XOR:  alu_s = rs1_val_r ^ op_b_s;
            F3_SR:   alu_s = (funct7_s == F7_ALT) ? $unsigned($signed(rs1_val_r) >>> shamt_s)
                                                  : rs1_val_r >> shamt_s;
            F3_OR:   alu_s = rs1_val_r | op_b_s;
            F3_AND:  alu_s = rs1_val_r & op_b_s;
            default: alu_s = rs1_val_r + op_b_s;
        endcase
    end

    // Branch condition evaluation.
    always_comb begin
        case (funct3_s)
            F3_BEQ:  take_s = (rs1_val_r == rs2_val_r);
            F3_BNE:  take_s = (rs1_val_r != rs2_val_r);
            F3_BLT:  take_s = ($signed(rs1_val_r) < $signed(rs2_val_r));
            F3_BGE:  take_s = ($signed(rs1_val_r) >= $signed(rs2_val_r));
            F3_BLTU: take_s = (rs1_val_r < rs2_val_r);
            F3_BGEU: take_s = (rs1_val_r >= rs2_val_r);
            default: take_s = 1'b0;
        endcase
    end

    // Next pc and rd write-back for everything resolved in EXEC; loads and system ops fall to default.
    always_comb begin
        next_pc_s    = pc_plus4_s;
        exec_we_s    = 1'b0;
        exec_wdata_s = alu_s;
        case (opcode_s)
            OPC_LUI: begin
                exec_we_s    = 1'b1;
                exec_wdata_s = imm_u_s;
            end
            OPC_AUIPC: begin
                exec_we_s    = 1'b1;
                exec_wdata_s = pc_r + imm_u_s;
            end
            OPC_JAL: begin
                exec_we_s    = 1'b1;
                exec_wdata_s = pc_plus4_s;
                next_pc_s    = pc_r + imm_j_s;
            end
            OPC_JALR: begin
                exec_we_s    = 1'b1;
                exec_wdata_s = pc_plus4_s;
                next_pc_s    = {jalr_sum_s[31:1], 1'b0};
            end
            OPC_BRANCH: begin
                if (take_s) begin
                    next_pc_s = pc_r + imm_b_s;
                end else begin
                    next_pc_s = pc_plus4_s;
                end
            end
            OPC_OPIMM, OPC_OP: begin
                exec_we_s = 1'b1;
            end
            default: begin
                next_pc_s = pc_plus4_s;
            end
        endcase
    end

    // Store lane placement; unknown store widths write nothing.
    always_comb begin
        case (funct3_s)
            F3_SB: begin
                mem_be    = 4'b0001 << ls_addr_s[1:0];
                mem_wdata = {4{rs2_val_r[7:0]}};
            end
            F3_SH: begin
                mem_be    = ls_addr_s[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{rs2_val_r[15:0]}};
            end
            F3_SW: begin
                mem_be    = 4'b1111;
                mem_wdata = rs2_val_r;
            end
            default: begin
                mem_be    = 4'b0000;
                mem_wdata = rs2_val_r;
            end
        endcase
    end

    assign mem_addr   = (state_r == ST_FETCH) ? pc_r : ls_addr_s;
    assign mem_we     = (state_r == ST_EXEC) && (opcode_s == OPC_STORE) && (rst_n == RstDisable);
    assign rf_we_s    = ((state_r == ST_EXEC) && exec_we_s) || (state_r == ST_LOAD);
    assign rf_wdata_s = (state_r == ST_LOAD) ? load_extract(funct3_s, mem_rdata, ls_addr_s[1:0])
                                             : exec_wdata_s;

    // Control FSM; operands are captured in DECODE so EXEC/LOAD see stable values.
    always_ff @(posedge clk) begin
        if (rst_n == RstEnable) begin
            state_r   <= ST_FETCH;
            pc_r      <= RESET_PC;
            instr_r   <= 32'd0;
            rs1_val_r <= 32'd0;
            rs2_val_r <= 32'd0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    state_r <= ST_DECODE;
                end
                ST_DECODE: begin
                    instr_r   <= mem_rdata;
                    rs1_val_r <= rf_rdata1_s;
                    rs2_val_r <= rf_rdata2_s;
                    state_r   <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (halt_s) begin
                        state_r <= ST_HALT;
                    end else if (is_load_s) begin
                        state_r <= ST_LOAD;
                    end else begin
                        pc_r    <= next_pc_s;
                        state_r <= ST_FETCH;
                    end
                end
                ST_LOAD: begin
                    pc_r    <= pc_plus4_s;
                    state_r <= ST_FETCH;
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    state_r <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: rtl/soc_top_mem.sv
// Unified instruction/data memory: sirv_sim_ram array plus the srambus byte-address wrapper.
module sirv_sim_ram #(
    parameter int DW    = 32,
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic            clk,
    input  logic [AW-1:0]   addr,
    input  logic            we,
    input  logic [DW/8-1:0] be,
    input  logic [DW-1:0]   wdata,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] mem_r [0:DEPTH-1];
    logic [DW-1:0] rdata_r;

    // One-cycle read latency; byte-lane writes. Contents are never reset so preloads survive.
    always_ff @(posedge clk) begin
        rdata_r <= mem_r[addr];
        for (int i = 0; i < DW/8; i++) begin
            if (we && be[i]) begin
                mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = rdata_r;

endmodule

module srambus #(
    parameter int MEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);

    localparam int AW = $clog2(MEM_WORDS);

    sirv_sim_ram #(
        .DW    (32),
        .DEPTH (MEM_WORDS),
        .AW    (AW)
    ) sirv_sim_ram_inst (
        .clk   (clk),
        .addr  (addr[AW+1:2]),
        .we    (we),
        .be    (be),
        .wdata (wdata),
        .rdata (rdata)
    );

endmodule

// File: rtl/soc_top_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port, x0 hard-wired to zero.
module regfile
    import soc_top_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [DATA_WIDTH-1:0] rf [0:31];

    // Register storage; reset clears every entry and wins over a pending write.
    always_ff @(posedge clk) begin
        if (rst_n == RstEnable) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= 32'd0;
            end
        end else if (we && (waddr != 5'd0)) begin
            rf[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : rf[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : rf[raddr2];

endmodule

// File: rtl/soc_top.sv
// SoC top: RV32I core plus unified memory. Optional macro SOC_EBREAK_HALT_EN makes EBREAK halt the core.
module soc_top
    import soc_top_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 4096
) (
    input  logic clk,
    input  logic rst_n
);

    logic [31:0] mem_addr_s;
    logic        mem_we_s;
    logic [3:0]  mem_be_s;
    logic [31:0] mem_wdata_s;
    logic [31:0] mem_rdata_s;

    riscv_core #(
        .RESET_PC (RESET_PC)
    ) riscv_core_inst (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_addr  (mem_addr_s),
        .mem_we    (mem_we_s),
        .mem_be    (mem_be_s),
        .mem_wdata (mem_wdata_s),
        .mem_rdata (mem_rdata_s)
    );

    srambus #(
        .MEM_WORDS (MEM_WORDS)
    ) srambus_inst (
        .clk   (clk),
        .addr  (mem_addr_s),
        .we    (mem_we_s),
        .be    (mem_be_s),
        .wdata (mem_wdata_s),
        .rdata (mem_rdata_s)
    );

endmodule

// File: tb/tb_soc_top.sv
// Bench for soc_top: directed programs plus random ALU/load/store programs checked against an ISA-level model.
module tb_soc_top;
    import soc_top_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [31:0] m_rf [0:31];
    logic [7:0]  m_mem [int];

    always #5 clk = ~clk;

    soc_top dut (.clk(clk), .rst_n(rst_n));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rd, op};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return enc_i(imm, rs1, 3'd0, rd, 7'h13);
    endfunction

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

    // Mnemonic index -> encoding fields and architectural result.
    // 0 ADD 1 SUB 2 SLL 3 SLT 4 SLTU 5 XOR 6 SRL 7 SRA 8 OR 9 AND
    function automatic logic [2:0] op_f3(input int idx);
        case (idx)
            0, 1: return 3'd0;
            2: return 3'd1;
            3: return 3'd2;
            4: return 3'd3;
            5: return 3'd4;
            6, 7: return 3'd5;
            8: return 3'd6;
            default: return 3'd7;
        endcase
    endfunction
    function automatic logic [6:0] op_f7(input int idx);
        return (idx == 1 || idx == 7) ? 7'h20 : 7'h00;
    endfunction
    function automatic logic [31:0] ref_op(input int idx, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (idx)
            0: r = a + b;
            1: r = a - b;
            2: r = a << b[4:0];
            3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4: r = (a < b) ? 32'd1 : 32'd0;
            5: r = a ^ b;
            6: r = a >> b[4:0];
            7: r = $signed(a) >>> b[4:0];
            8: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] mget(input int addr);
        return m_mem.exists(addr) ? m_mem[addr] : 8'h00;
    endfunction

    function automatic logic [31:0] mem_word(input int idx);
        return dut.srambus_inst.sirv_sim_ram_inst.mem_r[idx];
    endfunction
    function automatic logic [31:0] reg_val(input int idx);
        return dut.riscv_core_inst.regfile_inst.rf[idx];
    endfunction

    task automatic start_prog(input logic [31:0] p[$]);
        rst_n = 1'b0;
        for (int i = 0; i < 4096; i++) dut.srambus_inst.sirv_sim_ram_inst.mem_r[i] = 32'h0;
        foreach (p[i]) dut.srambus_inst.sirv_sim_ram_inst.mem_r[i] = p[i];
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_to(input logic [31:0] end_pc, input int budget, input string tag);
        int c;
        c = 0;
        while (dut.riscv_core_inst.pc_r !== end_pc && c < budget) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_reach"}, dut.riscv_core_inst.pc_r, end_pc);
        repeat (6) @(negedge clk);
    endtask

    initial begin
        logic [31:0] p[$];
        logic [31:0] a, b, u, res, w;
        logic [11:0] imm12;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] orv;
        int idx, kind, off, sz;

        // REQ-025 program, reset held for 40 ns
        p = '{addi(5'd27, 5'd0, 12'd1), addi(5'd26, 5'd0, 12'd1), enc_j(21'd0, 5'd0)};
        foreach (p[i]) dut.srambus_inst.sirv_sim_ram_inst.mem_r[i] = p[i];
        repeat (4) @(negedge clk);
        check("rst_pc", dut.riscv_core_inst.pc_r, 32'h0);
        check("rst_state", {29'd0, dut.riscv_core_inst.state_r}, {29'd0, ST_FETCH});
        orv = 32'd0;
        for (int i = 0; i < 32; i++) orv = orv | reg_val(i);
        check("rst_rf_zero", orv, 32'h0);
        rst_n = 1'b1;
        run_to(32'h8, 60, "p1");
        check("p1_x26", reg_val(26), 32'd1);
        check("p1_x27", reg_val(27), 32'd1);
        check("p1_pc_loop", dut.riscv_core_inst.pc_r, 32'h8);

        // Load/store lanes
        p = '{enc_u(20'h12345, 5'd5, 7'h37), addi(5'd5, 5'd5, 12'h678), enc_s(12'h100, 5'd5, 5'd0, 3'd2),
              enc_i(12'h101, 5'd0, 3'd0, 5'd6, 7'h03), enc_i(12'h102, 5'd0, 3'd5, 5'd7, 7'h03), enc_j(21'd0, 5'd0)};
        start_prog(p);
        run_to(32'h14, 80, "p2");
        check("p2_x5", reg_val(5), 32'h12345678);
        check("p2_x6", reg_val(6), 32'h00000056);
        check("p2_x7", reg_val(7), 32'h00001234);
        check("p2_mem", mem_word(32'h40), 32'h12345678);

        // Signed/unsigned compare and shifts
        p = '{addi(5'd1, 5'd0, 12'hFFF), enc_r(7'h00, 5'd1, 5'd0, 3'd3, 5'd2), enc_r(7'h00, 5'd1, 5'd0, 3'd2, 5'd3),
              enc_i(12'h404, 5'd1, 3'd5, 5'd4, 7'h13), enc_i(12'h01C, 5'd1, 3'd5, 5'd5, 7'h13), enc_j(21'd0, 5'd0)};
        start_prog(p);
        run_to(32'h14, 80, "p3");
        check("p3_sltu", reg_val(2), 32'd1);
        check("p3_slt", reg_val(3), 32'd0);
        check("p3_srai", reg_val(4), 32'hFFFFFFFF);
        check("p3_srli", reg_val(5), 32'h0000000F);

        // Branch not taken, JAL skipping one instruction
        p = '{addi(5'd1, 5'd0, 12'd5), enc_b(13'd8, 5'd0, 5'd1, 3'd0), addi(5'd2, 5'd0, 12'd7),
              enc_j(21'd8, 5'd3), addi(5'd2, 5'd0, 12'd9), enc_j(21'd0, 5'd0)};
        start_prog(p);
        run_to(32'h14, 80, "p4");
        check("p4_x2", reg_val(2), 32'd7);
        check("p4_x3", reg_val(3), 32'h10);

        // Aliasing, misaligned word load, JALR with rd == rs1
        p = '{addi(5'd1, 5'd0, 12'h02A), enc_u(20'h00004, 5'd2, 7'h37), enc_s(12'h100, 5'd1, 5'd2, 3'd2),
              enc_i(12'h100, 5'd0, 3'd2, 5'd3, 7'h03), enc_i(12'h103, 5'd0, 3'd2, 5'd4, 7'h03),
              addi(5'd5, 5'd0, 12'h021), enc_i(12'h000, 5'd5, 3'd0, 5'd5, 7'h67), addi(5'd6, 5'd0, 12'd1),
              enc_j(21'd0, 5'd0)};
        start_prog(p);
        run_to(32'h20, 120, "p7");
        check("p7_alias", reg_val(3), 32'h2A);
        check("p7_lw_mis", reg_val(4), 32'h2A);
        check("p7_jalr_link", reg_val(5), 32'h1C);
        check("p7_skipped", reg_val(6), 32'h0);

        // x0 write discard and one-cycle reset pulse
        p = '{addi(5'd0, 5'd0, 12'd5), addi(5'd1, 5'd0, 12'd3), enc_j(21'd0, 5'd0)};
        start_prog(p);
        run_to(32'h8, 60, "p5");
        check("p5_x0", reg_val(0), 32'h0);
        check("p5_x1", reg_val(1), 32'd3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("p5_rst_pc", dut.riscv_core_inst.pc_r, 32'h0);
        orv = 32'd0;
        for (int i = 0; i < 32; i++) orv = orv | reg_val(i);
        check("p5_rst_rf", orv, 32'h0);
        run_to(32'h8, 60, "p5b");
        check("p5_rerun_x1", reg_val(1), 32'd3);

        // Reset landing on the EXEC edge of a store aborts the write
        p = '{addi(5'd1, 5'd0, 12'h055), enc_s(12'h200, 5'd1, 5'd0, 3'd2), enc_j(21'd0, 5'd0)};
        start_prog(p);
        idx = 0;
        while (!(dut.riscv_core_inst.state_r == ST_EXEC && dut.riscv_core_inst.pc_r == 32'h4) && idx < 60) begin
            @(negedge clk);
            idx++;
        end
        check("p6_at_store", dut.riscv_core_inst.pc_r, 32'h4);
        rst_n = 1'b0;
        @(negedge clk);
        check("p6_no_write", mem_word(32'h80), 32'h0);
        check("p6_pc_reset", dut.riscv_core_inst.pc_r, 32'h0);
        check("p6_rf_reset", reg_val(1), 32'h0);
        rst_n = 1'b1;
        run_to(32'h8, 60, "p6");
        check("p6_write", mem_word(32'h80), 32'h55);

        // EBREAK behaviour depends on build configuration
        p = '{addi(5'd1, 5'd0, 12'd1), INSN_EBREAK, addi(5'd2, 5'd0, 12'd2), enc_j(21'd0, 5'd0)};
        start_prog(p);
`ifdef SOC_EBREAK_HALT_EN
        run_to(32'h4, 60, "ebk");
        repeat (100) @(negedge clk);
        check("ebk_pc_hold", dut.riscv_core_inst.pc_r, 32'h4);
        check("ebk_no_next", reg_val(2), 32'h0);
`else
        run_to(32'hC, 60, "ebk");
        check("ebk_next_ran", reg_val(2), 32'd2);
`endif

        // Random ALU/load/store programs against the ISA model
        for (int it = 0; it < 4; it++) begin
            p.delete();
            m_mem.delete();
            for (int r = 0; r < 32; r++) m_rf[r] = 32'h0;
            for (int r = 1; r < 8; r++) begin
                u = $urandom();
                rd = r[4:0];
                p.push_back(enc_u(u[31:12], rd, 7'h37));
                p.push_back(addi(rd, rd, u[11:0]));
                m_rf[r] = {u[31:12], 12'd0} + sext12(u[11:0]);
            end
            for (int k = 0; k < 24; k++) begin
                kind = $urandom_range(0, 3);
                rd = 5'($urandom_range(0, 7));
                rs1 = 5'($urandom_range(0, 7));
                rs2 = 5'($urandom_range(0, 7));
                a = m_rf[rs1];
                b = m_rf[rs2];
                off = 32'h400 + $urandom_range(0, 255);
                imm12 = off[11:0];
                case (kind)
                    0: begin
                        idx = $urandom_range(0, 9);
                        p.push_back(enc_r(op_f7(idx), rs2, rs1, op_f3(idx), rd));
                        res = ref_op(idx, a, b);
                    end
                    1: begin
                        idx = $urandom_range(0, 9);
                        if (idx == 1) idx = 0;
                        u = $urandom();
                        imm12 = u[11:0];
                        if (idx == 2 || idx == 6 || idx == 7) imm12 = {op_f7(idx), u[4:0]};
                        p.push_back(enc_i(imm12, rs1, op_f3(idx), rd, 7'h13));
                        res = ref_op(idx, a, sext12(imm12));
                    end
                    2: begin
                        sz = $urandom_range(0, 2);
                        p.push_back(enc_s(imm12, rs2, 5'd0, 3'(sz)));
                        if (sz == 0) m_mem[off] = b[7:0];
                        else if (sz == 1) begin
                            m_mem[off & ~1] = b[7:0];
                            m_mem[(off & ~1) + 1] = b[15:8];
                        end else begin
                            for (int j = 0; j < 4; j++) m_mem[(off & ~3) + j] = b[8*j +: 8];
                        end
                        res = m_rf[rd];
                    end
                    default: begin
                        sz = $urandom_range(0, 4);
                        if (sz == 3) sz = 5;
                        p.push_back(enc_i(imm12, 5'd0, 3'(sz), rd, 7'h03));
                        w = {mget((off & ~3) + 3), mget((off & ~3) + 2), mget((off & ~3) + 1), mget(off & ~3)};
                        case (sz)
                            0: res = {{24{mget(off)[7]}}, mget(off)};
                            1: res = {{16{mget((off & ~1) + 1)[7]}}, mget((off & ~1) + 1), mget(off & ~1)};
                            2: res = w;
                            4: res = {24'd0, mget(off)};
                            default: res = {16'd0, mget((off & ~1) + 1), mget(off & ~1)};
                        endcase
                    end
                endcase
                if (rd != 5'd0) m_rf[rd] = res;
            end
            p.push_back(enc_j(21'd0, 5'd0));
            start_prog(p);
            run_to(32'((p.size() - 1) * 4), p.size() * 4 + 40, $sformatf("rnd%0d", it));
            for (int r = 0; r < 8; r++) check($sformatf("rnd%0d_x%0d", it, r), reg_val(r), m_rf[r]);
            for (int wi = 32'h100; wi < 32'h141; wi++) begin
                w = {mget(wi*4 + 3), mget(wi*4 + 2), mget(wi*4 + 1), mget(wi*4)};
                check($sformatf("rnd%0d_mem%0h", it, wi), mem_word(wi), w);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
